// File: rtl/cpu_pkg.sv
// Shared pipeline constants: bypass select encodings, stall cause codes and
// the default register address width.
package cpu_pkg;
    localparam int DEFAULT_REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MWB = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    localparam logic [1:0] STALL_NONE = 2'b00;
    localparam logic [1:0] STALL_LU   = 2'b01;
    localparam logic [1:0] STALL_SB   = 2'b10;
endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for multi-cycle results: one bit per architectural
// register, set on issue, cleared on completion, with NUM_RD lookup ports.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int REG_AW = DEFAULT_REG_AW,
    parameter int NUM_RD = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [REG_AW-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [REG_AW-1:0]        clr_addr,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pending,
    output logic                     busy
);
    localparam int DEPTH = 1 << REG_AW;

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Set is applied after clear: a fresh issue to the same register is the
    // newer writer and must stay pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) pending_d[clr_addr] = 1'b0;
        if (set_en) pending_d[set_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            assign rd_pending[gi] = pending_q[rd_addr[gi*REG_AW +: REG_AW]];
        end
    endgenerate

    assign busy = |pending_q;
endmodule

// File: rtl/hazard_forward_unit.sv
// Operand bypass selection, load-use interlock, multi-cycle scoreboard
// interlock and saturating stall-cycle counter for the ID/EX stages.
module hazard_forward_unit
    import cpu_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = DEFAULT_REG_AW,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_read,
    input  logic                      ex_mc_issue,
    input  logic [REG_AW-1:0]         exm_rd,
    input  logic                      exm_reg_write,
    input  logic [REG_AW-1:0]         mwb_rd,
    input  logic                      mwb_reg_write,
    input  logic                      mc_done,
    input  logic [REG_AW-1:0]         mc_rd,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic [1:0]                stall_cause,
    output logic                      mc_busy,
    output logic [CNT_W-1:0]          stall_cnt
);
    logic [NUM_SRC-1:0] lu_src;
    logic [NUM_SRC:0]   sb_pend;
    logic               lu;
    logic               sb;
    logic               exm_valid;
    logic               mwb_valid;

    assign exm_valid = exm_reg_write && (exm_rd != '0);
    assign mwb_valid = mwb_reg_write && (mwb_rd != '0);

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] ex_src;
            assign ex_src = ex_rs[gi*REG_AW +: REG_AW];
            assign fwd_sel[2*gi +: 2] =
                (exm_valid && exm_rd == ex_src) ? FWD_EXM :
                (mwb_valid && mwb_rd == ex_src) ? FWD_MWB : FWD_RF;
            assign lu_src[gi] = id_rs_used[gi] && (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
        end
    endgenerate

    assign lu = ex_mem_read && ex_reg_write && (ex_rd != '0) && (|lu_src);

    // Lookup ports 0..NUM_SRC-1 serve the ID sources, the top port serves id_rd.
    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .NUM_RD (NUM_SRC + 1)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (ex_mc_issue && ex_reg_write && (ex_rd != '0)),
        .set_addr   (ex_rd),
        .clr_en     (mc_done),
        .clr_addr   (mc_rd),
        .rd_addr    ({id_rd, id_rs}),
        .rd_pending (sb_pend),
        .busy       (mc_busy)
    );

    assign sb = (|(id_rs_used & sb_pend[NUM_SRC-1:0])) || (id_reg_write && sb_pend[NUM_SRC]);

    assign stall  = lu || sb;
    assign bubble = stall;

    always_comb begin
        stall_cause = STALL_NONE;
        if (lu)      stall_cause = STALL_LU;
        else if (sb) stall_cause = STALL_SB;
    end

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
endmodule
